tm_shiftreg_ctrl: RTL and testbench
===================================

Name: tm_shiftreg_ctrl

Overview:
- Sequences a write/readback of the TM configuration shift register.
- Takes the DATA_WIDTH-bit word assembled by the config-data combiner and shifts it out serially, MSB first, on a divided shift clock.
- Captures the register's previous contents from the serial output, then pulses a load strobe.
- Sits between the config combiner and the chip pins; software triggers it through a pulse register.

Parameters:
DATA_WIDTH, 50, number of bits in the TM shift register.
CNT_WIDTH, 8, bit counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
CLK_DIV, 2, clk_in cycles per sr_clk half-period; must be >= 1.
DIV_WIDTH, 4, phase counter width; must satisfy 2^DIV_WIDTH > CLK_DIV.

Ports:
clk_in  input  1  single control clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a write; sampled only in IDLE.
data_in  input  DATA_WIDTH  word to write; captured on the accepted start.
sr_dout  input  1  serial output of the TM shift register (readback).
sr_clk  output  1  shift clock to the TM register.
sr_din  output  1  serial data to the TM register.
sr_load  output  1  parallel-load strobe to the TM register.
busy  output  1  high from the first shift cycle through the end of LATCH.
done  output  1  one-cycle pulse at completion.
data_out  output  DATA_WIDTH  readback word from the last completed operation.

Behaviour:
- Reset, asynchronous: state=IDLE.
  - sr_clk, sr_din, sr_load, busy, done = 0.
  - data_out, shadow, readback registers and all counters = 0.
- All outputs are registered.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE, start=1 at edge T:
  - shadow <= data_in; bit_cnt <= 0; phase_cnt <= 0.
  - Next state SHIFT_LO; busy=1 from T+1.
  - start in any other state is ignored and is not queued.
- SHIFT_LO: sr_clk=0, sr_din=shadow[DATA_WIDTH-1], held for CLK_DIV cycles.
  - On its last cycle: rb <= {rb[DATA_WIDTH-2:0], sr_dout}; go to SHIFT_HI.
- SHIFT_HI: sr_clk=1 and sr_din unchanged, held for CLK_DIV cycles.
  - On its last cycle: shadow <= shadow<<1.
  - If bit_cnt==DATA_WIDTH-1, go to LATCH; else bit_cnt++ and go to SHIFT_LO.
- LATCH: sr_clk=0, sr_din=0, sr_load=1, held for CLK_DIV cycles; then go to DONE.
- DONE, single cycle:
  - done=1, busy=0, data_out <= rb.
  - Next state IDLE. A start in the DONE cycle is ignored.
- Timing:
  - done asserts at T+1+2*CLK_DIV*DATA_WIDTH+CLK_DIV; this is T+203 at defaults.
  - Exactly DATA_WIDTH sr_clk rising edges per operation.
  - sr_din is stable for CLK_DIV cycles either side of each sr_clk rising edge.
- data_out holds its value between DONE states; data_in may change freely once start has been accepted.
- Reset mid-operation:
  - Pins go to 0 immediately; no done is generated.
  - data_out is cleared; the TM register contents are undefined.
  - The next start runs a full operation.
- phase_cnt wraps to 0 at each state change; bit_cnt never exceeds DATA_WIDTH-1.

Decomposition:
- Shared package tm_shiftreg_pkg:
  - state encoding localparams ST_IDLE, ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH, ST_DONE (3-bit);
  - default DATA_WIDTH.
- One sub-module, tm_sr_phase_timer (DIV_WIDTH, CLK_DIV):
  - counts clk_in cycles within a phase;
  - emits phase_end on the last cycle;
  - clears on a phase_restart input.
- The FSM and shift/readback registers stay in tm_shiftreg_ctrl.

Test Plan:
- Bench model: a behavioural DATA_WIDTH-bit register clocked by sr_clk, with sr_dout = model MSB.
1. Hold rst=1 for 100 ns, then release -> all outputs 0; state IDLE; no sr_clk edges for 1 us with start=0.
2. Reset model to 0, then start with data_in=50'h2_ABCD_1234_5678 -> 50 sr_clk rising edges; model then holds 50'h2_ABCD_1234_5678. sr_load is high for 2 cycles, done pulses at T+203, data_out=0.
3. Immediately follow with start, data_in=50'h1_5555_5555_5555 -> data_out=50'h2_ABCD_1234_5678 at done; model then holds 50'h1_5555_5555_5555.
4. Pulse start at T+10 and T+100, and in the DONE cycle -> exactly one done; busy never deasserts early; model holds the first word only.
5. Assert rst after the 20th sr_clk rising edge -> sr_clk, sr_load and busy drop to 0 within the reset; no done. A following start with 50'h3_FFFF_0000_FFFF completes normally, done at T+203.
6. Instance with CLK_DIV=1 -> sr_clk period is 2 clk_in cycles; done at T+102; readback correct for 50'h0_0000_0000_0001 (single-bit LSB case).

Source files
------------

// File: rtl/tm_shiftreg_pkg.sv
// Shared definitions for the TM configuration shift-register controller:
// FSM state encoding, default register length and small state helpers.
package tm_shiftreg_pkg;

  // Length of the TM configuration shift register.
  localparam int TM_DATA_WIDTH = 50;

  // Controller state encoding (3-bit).
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DONE     = 3'd4
  } tm_state_e;

  // True in either half of a serial bit period.
  function automatic logic is_shifting(input tm_state_e s);
    return (s == ST_SHIFT_LO) || (s == ST_SHIFT_HI);
  endfunction

  // True whenever the controller owns the TM register pins.
  function automatic logic is_busy(input tm_state_e s);
    return (s == ST_SHIFT_LO) || (s == ST_SHIFT_HI) || (s == ST_LATCH);
  endfunction

endpackage

// File: rtl/tm_sr_phase_timer.sv
// Phase timer: counts clk_in cycles inside one controller phase and flags
// the last cycle of the phase. Every phase is CLK_DIV cycles long.
module tm_sr_phase_timer #(
  parameter int DIV_WIDTH = 4,
  parameter int CLK_DIV   = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic phase_restart,
  output logic phase_end
);

  logic [DIV_WIDTH-1:0] phase_cnt_q;
  logic [DIV_WIDTH-1:0] phase_cnt_d;

  assign phase_end = (phase_cnt_q == DIV_WIDTH'(CLK_DIV - 1));

  // Next count: restart and end-of-phase both wrap to zero, otherwise count up.
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    if (phase_restart) begin
      phase_cnt_d = '0;
    end else if (phase_end) begin
      phase_cnt_d = '0;
    end else begin
      phase_cnt_d = phase_cnt_q + DIV_WIDTH'(1);
    end
  end

  // Phase counter register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      phase_cnt_q <= '0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
    end
  end

endmodule

// File: rtl/tm_shiftreg_ctrl.sv
// TM configuration shift-register controller. Shifts a DATA_WIDTH-bit word
// out MSB first on a divided shift clock, captures the previous register
// contents from the serial readback line, then pulses the parallel load.
// All pin-level outputs come straight from flops computed off the next state,
// so they change together with the state register.
module tm_shiftreg_ctrl
  import tm_shiftreg_pkg::*;
#(
  parameter int DATA_WIDTH = TM_DATA_WIDTH,
  parameter int CNT_WIDTH  = 8,
  parameter int CLK_DIV    = 2,
  parameter int DIV_WIDTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sr_dout,
  output logic                  sr_clk,
  output logic                  sr_din,
  output logic                  sr_load,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out
);

  tm_state_e state_q;
  tm_state_e state_d;

  logic [DATA_WIDTH-1:0] shadow_q;
  logic [DATA_WIDTH-1:0] shadow_d;
  logic [DATA_WIDTH-1:0] rb_q;
  logic [DATA_WIDTH-1:0] rb_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q;
  logic [CNT_WIDTH-1:0]  bit_cnt_d;

  logic sr_clk_q;
  logic sr_clk_d;
  logic sr_din_q;
  logic sr_din_d;
  logic sr_load_q;
  logic sr_load_d;
  logic busy_q;
  logic busy_d;
  logic done_q;
  logic done_d;

  logic phase_end;
  logic phase_restart;

  // The timer is held at zero while idle and restarted on every state change,
  // so each phase starts counting from its first cycle.
  assign phase_restart = (state_q == ST_IDLE) || (state_d != state_q);

  tm_sr_phase_timer #(
    .DIV_WIDTH (DIV_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_phase_timer (
    .clk_in        (clk_in),
    .rst           (rst),
    .phase_restart (phase_restart),
    .phase_end     (phase_end)
  );

  // Next-state and datapath: sequencing of shift, readback capture and latch.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    rb_d       = rb_q;
    bit_cnt_d  = bit_cnt_q;
    data_out_d = data_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d  = data_in;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT_LO;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT_LO: begin
        // Readback sampled at the end of the low half, just before sr_clk rises.
        if (phase_end) begin
          rb_d    = {rb_q[DATA_WIDTH-2:0], sr_dout};
          state_d = ST_SHIFT_HI;
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          shadow_d = {shadow_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
            state_d = ST_LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_LATCH: begin
        // Publish the readback on entry to DONE so it is valid alongside done.
        if (phase_end) begin
          data_out_d = rb_q;
          state_d    = ST_DONE;
        end else begin
          state_d    = ST_LATCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin-level outputs derived from the state being entered.
  always_comb begin
    sr_clk_d  = 1'b0;
    sr_din_d  = 1'b0;
    sr_load_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    if (is_shifting(state_d)) begin
      sr_din_d = shadow_d[DATA_WIDTH-1];
    end else begin
      sr_din_d = 1'b0;
    end
    sr_clk_d  = (state_d == ST_SHIFT_HI);
    sr_load_d = (state_d == ST_LATCH);
    busy_d    = is_busy(state_d);
    done_d    = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      rb_q       <= '0;
      bit_cnt_q  <= '0;
      data_out_q <= '0;
      sr_clk_q   <= 1'b0;
      sr_din_q   <= 1'b0;
      sr_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      rb_q       <= rb_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out_q <= data_out_d;
      sr_clk_q   <= sr_clk_d;
      sr_din_q   <= sr_din_d;
      sr_load_q  <= sr_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sr_clk   = sr_clk_q;
  assign sr_din   = sr_din_q;
  assign sr_load  = sr_load_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_tm_shiftreg_ctrl.sv
// Directed bench for tm_shiftreg_ctrl. A behavioural TM register (shifted on
// sr_clk rising, readback = its MSB) sits on each instance's pins.
// Cycle numbering: cycle k is the cycle following clk_in rising edge k, with
// T the edge that samples start, so "done at T+203" means done is seen after
// the 202nd edge following T.
module tb_tm_shiftreg_ctrl;

  localparam int DW = 50;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst = 1'b1;

  // Instance 0: default CLK_DIV=2
  logic          start0 = 1'b0;
  logic [DW-1:0] data_in0 = '0;
  logic          sr_dout0, sr_clk0, sr_din0, sr_load0, busy0, done0;
  logic [DW-1:0] data_out0;

  // Instance 1: CLK_DIV=1
  logic          start1 = 1'b0;
  logic [DW-1:0] data_in1 = '0;
  logic          sr_dout1, sr_clk1, sr_din1, sr_load1, busy1, done1;
  logic [DW-1:0] data_out1;

  int checks = 0;
  int failures = 0;

  tm_shiftreg_ctrl dut0 (
    .clk_in(clk_in), .rst(rst), .start(start0), .data_in(data_in0),
    .sr_dout(sr_dout0), .sr_clk(sr_clk0), .sr_din(sr_din0), .sr_load(sr_load0),
    .busy(busy0), .done(done0), .data_out(data_out0)
  );

  tm_shiftreg_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(8), .CLK_DIV(1), .DIV_WIDTH(4)) dut1 (
    .clk_in(clk_in), .rst(rst), .start(start1), .data_in(data_in1),
    .sr_dout(sr_dout1), .sr_clk(sr_clk1), .sr_din(sr_din1), .sr_load(sr_load1),
    .busy(busy1), .done(done1), .data_out(data_out1)
  );

  // Behavioural TM registers
  logic          model_clr0 = 1'b0;
  logic          model_clr1 = 1'b0;
  logic [DW-1:0] model0;
  logic [DW-1:0] model1;

  always @(posedge sr_clk0 or posedge model_clr0) begin
    if (model_clr0) model0 <= '0;
    else            model0 <= {model0[DW-2:0], sr_din0};
  end
  always @(posedge sr_clk1 or posedge model_clr1) begin
    if (model_clr1) model1 <= '0;
    else            model1 <= {model1[DW-2:0], sr_din1};
  end
  assign sr_dout0 = model0[DW-1];
  assign sr_dout1 = model1[DW-1];

  // Event counters (read as snapshots by the tests)
  int sr_edges0 = 0;
  int sr_edges1 = 0;
  int done_cnt0 = 0;
  always @(posedge sr_clk0) sr_edges0 <= sr_edges0 + 1;
  always @(posedge sr_clk1) sr_edges1 <= sr_edges1 + 1;
  always @(posedge clk_in) if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;

  // Run one operation on dut0. Extra start pulses are sampled at edges T+x1,
  // T+x2 (0 = none) and, if poke_done, at the edge ending the DONE cycle.
  task automatic run_op0(input logic [DW-1:0] word, input int x1, input int x2,
                         input bit poke_done, output int done_cyc, output int load_cyc,
                         output int busy_drop, output logic [DW-1:0] dout_at_done);
    done_cyc = -1; load_cyc = 0; busy_drop = 0; dout_at_done = 'x;
    @(negedge clk_in);
    start0 = 1'b1; data_in0 = word;
    @(posedge clk_in); #1;
    start0 = 1'b0; data_in0 = ~word;
    if (busy0 !== 1'b1) busy_drop++;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk_in); #1;
      start0 = 1'b0;
      if (done0 === 1'b1) begin
        done_cyc = n + 1;
        dout_at_done = data_out0;
        if (poke_done) begin start0 = 1'b1; data_in0 = 50'h3_0303_0303_0303; end
        break;
      end
      if (sr_load0 === 1'b1) load_cyc++;
      if (busy0 !== 1'b1) busy_drop++;
      if (n == x1 - 1 || n == x2 - 1) begin start0 = 1'b1; data_in0 = 50'h0_DEAD_BEEF_0000; end
    end
    @(posedge clk_in); #1;
    start0 = 1'b0;
  endtask

  // Run one operation on dut1 (CLK_DIV=1), also checking the sr_clk waveform.
  task automatic run_op1(input logic [DW-1:0] word, output int done_cyc,
                         output int clk_bad, output int load_cyc, output logic [DW-1:0] dout_at_done);
    done_cyc = -1; clk_bad = 0; load_cyc = 0; dout_at_done = 'x;
    @(negedge clk_in);
    start1 = 1'b1; data_in1 = word;
    @(posedge clk_in); #1;
    start1 = 1'b0;
    if (sr_clk1 !== 1'b0) clk_bad++;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk_in); #1;
      if (done1 === 1'b1) begin
        done_cyc = n + 1;
        dout_at_done = data_out1;
        break;
      end
      if (n <= 99 && sr_clk1 !== n[0]) clk_bad++;
      if (sr_load1 === 1'b1) load_cyc++;
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    #100;
    rst = 1'b0;
    #1;
    checks++; if (sr_clk0 !== 1'b0) begin failures++; $display("FAIL reset_sr_clk got=%b want=0", sr_clk0); end
    checks++; if (sr_din0 !== 1'b0) begin failures++; $display("FAIL reset_sr_din got=%b want=0", sr_din0); end
    checks++; if (sr_load0 !== 1'b0) begin failures++; $display("FAIL reset_sr_load got=%b want=0", sr_load0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done0); end
    checks++; if (data_out0 !== '0) begin failures++; $display("FAIL reset_data_out got=%h want=0", data_out0); end
    repeat (100) @(posedge clk_in);
    #1;
    checks++; if (sr_edges0 !== 0) begin failures++; $display("FAIL idle_sr_clk_edges got=%0d want=0", sr_edges0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy0); end
  endtask

  task automatic test_write();
    int e0, d0, dc, lc, bd;
    logic [DW-1:0] dout;
    model_clr0 = 1'b1; #1; model_clr0 = 1'b0;
    e0 = sr_edges0; d0 = done_cnt0;
    run_op0(50'h2_ABCD_1234_5678, 0, 0, 1'b0, dc, lc, bd, dout);
    checks++; if (sr_edges0 - e0 !== 50) begin failures++; $display("FAIL write_edges got=%0d want=50", sr_edges0 - e0); end
    checks++; if (model0 !== 50'h2_ABCD_1234_5678) begin failures++; $display("FAIL write_model got=%h want=2abcd12345678", model0); end
    checks++; if (lc !== 2) begin failures++; $display("FAIL write_load_cycles got=%0d want=2", lc); end
    checks++; if (dc !== 203) begin failures++; $display("FAIL write_done_cycle got=T+%0d want=T+203", dc); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL write_data_out got=%h want=0", dout); end
    checks++; if (bd !== 0) begin failures++; $display("FAIL write_busy_drop got=%0d want=0", bd); end
    checks++; if (done_cnt0 - d0 !== 1) begin failures++; $display("FAIL write_done_pulses got=%0d want=1", done_cnt0 - d0); end
    checks++; if ({busy0, done0} !== 2'b00) begin failures++; $display("FAIL write_after_done busy,done got=%b want=00", {busy0, done0}); end
  endtask

  task automatic test_back_to_back();
    int dc, lc, bd;
    logic [DW-1:0] dout;
    run_op0(50'h1_5555_5555_5555, 0, 0, 1'b0, dc, lc, bd, dout);
    checks++; if (dout !== 50'h2_ABCD_1234_5678) begin failures++; $display("FAIL b2b_data_out got=%h want=2abcd12345678", dout); end
    checks++; if (model0 !== 50'h1_5555_5555_5555) begin failures++; $display("FAIL b2b_model got=%h want=1555555555555", model0); end
    checks++; if (dc !== 203) begin failures++; $display("FAIL b2b_done_cycle got=T+%0d want=T+203", dc); end
  endtask

  task automatic test_ignored_starts();
    int e0, d0, dc, lc, bd;
    logic [DW-1:0] dout;
    e0 = sr_edges0; d0 = done_cnt0;
    run_op0(50'h0_1234_5678_9ABC, 10, 100, 1'b1, dc, lc, bd, dout);
    repeat (250) @(posedge clk_in);
    #1;
    checks++; if (done_cnt0 - d0 !== 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d want=1", done_cnt0 - d0); end
    checks++; if (sr_edges0 - e0 !== 50) begin failures++; $display("FAIL ignore_edges got=%0d want=50", sr_edges0 - e0); end
    checks++; if (bd !== 0) begin failures++; $display("FAIL ignore_busy_drop got=%0d want=0", bd); end
    checks++; if (model0 !== 50'h0_1234_5678_9ABC) begin failures++; $display("FAIL ignore_model got=%h want=123456789abc", model0); end
    checks++; if (dc !== 203) begin failures++; $display("FAIL ignore_done_cycle got=T+%0d want=T+203", dc); end
    checks++; if (dout !== 50'h1_5555_5555_5555) begin failures++; $display("FAIL ignore_data_out got=%h want=1555555555555", dout); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL ignore_idle_busy got=%b want=0", busy0); end
  endtask

  task automatic test_reset_mid_op();
    int e0, d0, dc, lc, bd, n;
    logic [DW-1:0] dout;
    e0 = sr_edges0;
    @(negedge clk_in);
    start0 = 1'b1; data_in0 = 50'h2_AAAA_BBBB_CCCC;
    @(posedge clk_in); #1;
    start0 = 1'b0;
    n = 0;
    while (sr_edges0 - e0 < 20 && n < 400) begin
      @(posedge clk_in); #1;
      n++;
    end
    checks++; if (sr_edges0 - e0 !== 20) begin failures++; $display("FAIL midrst_reach_edge20 got=%0d want=20", sr_edges0 - e0); end
    d0 = done_cnt0;
    rst = 1'b1;
    #1;
    checks++; if ({sr_clk0, sr_load0, busy0, sr_din0} !== 4'b0000) begin failures++; $display("FAIL midrst_pins sr_clk,sr_load,busy,sr_din got=%b want=0000", {sr_clk0, sr_load0, busy0, sr_din0}); end
    checks++; if (data_out0 !== '0) begin failures++; $display("FAIL midrst_data_out got=%h want=0", data_out0); end
    #30;
    rst = 1'b0;
    repeat (250) @(posedge clk_in);
    #1;
    checks++; if (done_cnt0 - d0 !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt0 - d0); end
    e0 = sr_edges0;
    run_op0(50'h3_FFFF_0000_FFFF, 0, 0, 1'b0, dc, lc, bd, dout);
    checks++; if (dc !== 203) begin failures++; $display("FAIL midrst_rerun_done_cycle got=T+%0d want=T+203", dc); end
    checks++; if (sr_edges0 - e0 !== 50) begin failures++; $display("FAIL midrst_rerun_edges got=%0d want=50", sr_edges0 - e0); end
    checks++; if (model0 !== 50'h3_FFFF_0000_FFFF) begin failures++; $display("FAIL midrst_rerun_model got=%h want=3ffff0000ffff", model0); end
  endtask

  task automatic test_clkdiv1();
    int e0, dc, cb, lc;
    logic [DW-1:0] dout;
    model_clr1 = 1'b1; #1; model_clr1 = 1'b0;
    e0 = sr_edges1;
    run_op1(50'h0_0000_0000_0001, dc, cb, lc, dout);
    checks++; if (dc !== 102) begin failures++; $display("FAIL div1_done_cycle got=T+%0d want=T+102", dc); end
    checks++; if (cb !== 0) begin failures++; $display("FAIL div1_sr_clk_period bad_cycles=%0d want=0", cb); end
    checks++; if (lc !== 1) begin failures++; $display("FAIL div1_load_cycles got=%0d want=1", lc); end
    checks++; if (sr_edges1 - e0 !== 50) begin failures++; $display("FAIL div1_edges got=%0d want=50", sr_edges1 - e0); end
    checks++; if (model1 !== 50'h0_0000_0000_0001) begin failures++; $display("FAIL div1_model got=%h want=1", model1); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL div1_first_data_out got=%h want=0", dout); end
    run_op1(50'h0_0000_0000_0000, dc, cb, lc, dout);
    checks++; if (dout !== 50'h0_0000_0000_0001) begin failures++; $display("FAIL div1_readback_lsb got=%h want=1", dout); end
    checks++; if (model1 !== '0) begin failures++; $display("FAIL div1_model2 got=%h want=0", model1); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_ignored_starts();
    test_reset_mid_op();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
